servo_pwm: RTL and testbench
============================

SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter cant_bits, default 20: width of pulse-width and period counter.
REQ-002 Parameter PERIODO, default 1_000_000: PWM period in clk cycles (20 ms at 50 MHz).
REQ-003 Parameter ANCHO_MIN, default 50_000: minimum legal pulse width in cycles (1 ms).
REQ-004 Parameter ANCHO_MAX, default 100_000: maximum legal pulse width in cycles (2 ms).
REQ-005 clk  input  1  sole clock; all state changes on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 ancho  input  cant_bits  requested pulse width in cycles.
REQ-008 nuevo  input  1  one-cycle strobe; ancho is valid while high.
REQ-009 habilitar  input  1  run request; low stops output at the next period boundary.
REQ-010 pwm  output  1  servo pulse, registered.
REQ-011 tomado  output  1  one-cycle pulse when a pending width becomes active.
REQ-012 fin_periodo  output  1  one-cycle pulse on the last cycle of each running period.
REQ-013 activo  output  cant_bits  width currently in use, registered.

Function
REQ-014 The block SHALL contain a two-state FSM: PARADO, CORRIENDO.
REQ-015 PARADO -> CORRIENDO on the first clk with habilitar=1; the period counter is 0 in that cycle.
REQ-016 CORRIENDO -> PARADO only on the cycle where the counter equals PERIODO-1 and habilitar=0; a period in progress is never truncated.
REQ-017 In CORRIENDO the counter SHALL increment by 1 per cycle and wrap from PERIODO-1 to 0; in PARADO it holds at 0.
REQ-018 In CORRIENDO, pwm SHALL be high exactly while counter < activo, i.e. activo consecutive cycles starting at counter=0; in PARADO pwm=0.
REQ-019 nuevo=1 SHALL capture ancho into a pending register and set a pending flag; a later nuevo before the boundary overwrites the pending value (last write wins).
REQ-020 At counter=PERIODO-1 with the pending flag set, activo SHALL load the pending value, the flag SHALL clear, and tomado SHALL pulse in that same cycle.
REQ-021 If nuevo coincides with the boundary cycle, the value arriving in that cycle SHALL be the one loaded into activo, with no loss.
REQ-022 A pending value captured in PARADO SHALL be loaded into activo on the next clk, with tomado pulsing in that cycle.
REQ-023 activo=0 SHALL yield pwm permanently low; activo >= PERIODO SHALL yield pwm permanently high. Both cases are reachable only without clamping.
REQ-024 fin_periodo SHALL pulse whenever counter=PERIODO-1 in CORRIENDO, including the final period before PARADO.

Reset
REQ-025 rst=1 SHALL force PARADO, counter=0, pwm=0, tomado=0, fin_periodo=0, pending flag=0, pending value=0, and activo=ANCHO_MIN.
REQ-026 rst asserted mid-period SHALL terminate the pulse immediately, with pwm=0 in the cycle after rst is sampled.
REQ-027 rst SHALL take priority over nuevo and habilitar.

Configuration
REQ-028 Macro SERVO_PWM_CLAMP_EN defined: a captured ancho SHALL be saturated to [ANCHO_MIN, ANCHO_MAX] before entering the pending register.
REQ-029 Macro SERVO_PWM_CLAMP_EN undefined: ancho SHALL be stored unmodified, and REQ-023 applies.

Structure
REQ-030 Shared package servo_pkg SHALL hold the default constants PERIODO, ANCHO_MIN and ANCHO_MAX, and the FSM state encoding.
REQ-031 The period counter, with its wrap and fin_periodo logic, SHALL be a sub-module servo_period_cnt; the FSM, pending buffer and comparator stay in servo_pwm.

Verification (bench parameters PERIODO=100, ANCHO_MIN=5, ANCHO_MAX=20, cant_bits=20)
REQ-032 rst, then habilitar=1 with no nuevo -> pwm high for 5 cycles of every 100; fin_periodo once per 100 cycles.
REQ-033 nuevo with ancho=12 at counter=40 -> current period keeps a 5-cycle pulse; tomado at counter=99; the next period has a 12-cycle pulse.
REQ-034 nuevo with ancho=8 at counter=30, then ancho=15 at counter=99 -> activo=15, and exactly one tomado pulse.
REQ-035 habilitar dropped at counter=3 -> the period runs to completion, then pwm=0 and the counter holds at 0; re-enabling restarts with counter=0.
REQ-036 With clamp: ancho=2 gives activo=5, and ancho=50 gives activo=20. Without clamp: ancho=0 keeps pwm low, and ancho=150 keeps pwm high.
REQ-037 rst at counter=2 while pwm=1 -> pwm=0 the next cycle, activo=5, state PARADO.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM block.
// Holds the default timing constants and the run/stop FSM state encoding.
//   PERIODO   : PWM period in clk cycles (20 ms at 50 MHz)
//   ANCHO_MIN : minimum legal pulse width in cycles (1 ms)
//   ANCHO_MAX : maximum legal pulse width in cycles (2 ms)
package servo_pkg;

  localparam int PERIODO   = 1_000_000;
  localparam int ANCHO_MIN = 50_000;
  localparam int ANCHO_MAX = 100_000;

  typedef enum logic {
    PARADO    = 1'b0,
    CORRIENDO = 1'b1
  } state_t;

endpackage

// File: rtl/servo_period_cnt.sv
// Period counter for the servo PWM block.
// Counts 0..PERIODO-1 while run is high and wraps to 0; holds at 0 otherwise.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   run      : count enable (FSM is in the running state)
//   cnt_next : value the counter takes at the next clk edge
//   fin      : high on the last cycle (count PERIODO-1) of a running period
module servo_period_cnt #(
  parameter int cant_bits = 20,
  parameter int PERIODO   = servo_pkg::PERIODO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic [cant_bits-1:0] cnt_next,
  output logic                 fin
);

  localparam logic [cant_bits-1:0] LAST = cant_bits'(PERIODO - 1);

  logic [cant_bits-1:0] cnt_reg;

  // Stopped or at the last count both lead back to 0.
  always_comb begin
    cnt_next = '0;
    if (run && (cnt_reg != LAST)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign fin = run && (cnt_reg == LAST);

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM generator.
// Produces a pulse of 'activo' cycles at the start of every PERIODO-cycle
// period. New widths are buffered and only take effect at a period boundary
// (or immediately on the next clk while stopped). Dropping habilitar lets the
// current period finish before stopping.
// Optional feature: define SERVO_PWM_CLAMP_EN to saturate captured widths to
// [ANCHO_MIN, ANCHO_MAX]; otherwise widths are stored unmodified.
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   ancho       : requested pulse width in cycles (valid with nuevo)
//   nuevo       : one-cycle strobe capturing ancho
//   habilitar   : run request
//   pwm         : registered servo pulse
//   tomado      : pulse in the cycle a pending width is transferred to activo
//   fin_periodo : pulse on the last cycle of each running period
//   activo      : registered width currently in use
module servo_pwm #(
  parameter int cant_bits = 20,
  parameter int PERIODO   = servo_pkg::PERIODO,
  parameter int ANCHO_MIN = servo_pkg::ANCHO_MIN,
  parameter int ANCHO_MAX = servo_pkg::ANCHO_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [cant_bits-1:0] ancho,
  input  logic                 nuevo,
  input  logic                 habilitar,
  output logic                 pwm,
  output logic                 tomado,
  output logic                 fin_periodo,
  output logic [cant_bits-1:0] activo
);

  import servo_pkg::*;

  localparam logic [cant_bits-1:0] MIN_W = cant_bits'(ANCHO_MIN);
  localparam logic [cant_bits-1:0] MAX_W = cant_bits'(ANCHO_MAX);

`ifdef SERVO_PWM_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  state_t               state_reg;
  logic                 pend_flag_reg;
  logic [cant_bits-1:0] pend_val_reg;
  logic [cant_bits-1:0] activo_reg;
  logic                 pwm_reg;

  logic                 running;
  logic                 run_next;
  logic                 boundary;
  logic                 load_bnd;
  logic                 load_stop;
  logic [cant_bits-1:0] cnt_next;
  logic [cant_bits-1:0] ancho_c;
  logic [cant_bits-1:0] load_val;
  logic [cant_bits-1:0] activo_next;

  servo_period_cnt #(
    .cant_bits (cant_bits),
    .PERIODO   (PERIODO)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (running),
    .cnt_next (cnt_next),
    .fin      (boundary)
  );

  always_comb begin
    running = (state_reg == CORRIENDO);

    ancho_c = ancho;
    if (CLAMP) begin
      if (ancho < MIN_W) begin
        ancho_c = MIN_W;
      end else if (ancho > MAX_W) begin
        ancho_c = MAX_W;
      end
    end

    // A width arriving in the boundary cycle bypasses the pending register
    // so it is not lost; otherwise the buffered value is used.
    load_bnd    = boundary && (pend_flag_reg || nuevo);
    load_stop   = !running && pend_flag_reg;
    load_val    = (boundary && nuevo) ? ancho_c : pend_val_reg;
    activo_next = (load_bnd || load_stop) ? load_val : activo_reg;

    // Leaving the running state is only allowed at the end of a period.
    if (running) begin
      run_next = !(boundary && !habilitar);
    end else begin
      run_next = habilitar;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= PARADO;
      pend_flag_reg <= 1'b0;
      pend_val_reg  <= '0;
      activo_reg    <= MIN_W;
      pwm_reg       <= 1'b0;
    end else begin
      state_reg  <= run_next ? CORRIENDO : PARADO;
      activo_reg <= activo_next;
      // Computed from next-cycle count/width so the registered pulse lines
      // up exactly with counter < activo.
      pwm_reg    <= run_next && (cnt_next < activo_next);

      if (load_bnd) begin
        pend_flag_reg <= 1'b0;
      end else if (nuevo) begin
        pend_flag_reg <= 1'b1;
        pend_val_reg  <= ancho_c;
      end else if (load_stop) begin
        pend_flag_reg <= 1'b0;
      end
    end
  end

  assign pwm         = pwm_reg;
  assign activo      = activo_reg;
  assign fin_periodo = boundary;
  assign tomado      = !rst && (load_bnd || load_stop);

endmodule

// File: tb/tb_servo_pwm.sv
// Self-checking bench for servo_pwm (PERIODO=100, ANCHO_MIN=5, ANCHO_MAX=20).
module tb_servo_pwm;

  localparam int P    = 100;
  localparam int AMIN = 5;
  localparam int AMAX = 20;
  localparam int W    = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         nuevo = 1'b0;
  logic         habilitar = 1'b0;
  logic [W-1:0] ancho = '0;
  logic         pwm;
  logic         tomado;
  logic         fin_periodo;
  logic [W-1:0] activo;

  always #5 clk = ~clk;

  servo_pwm #(
    .cant_bits (W),
    .PERIODO   (P),
    .ANCHO_MIN (AMIN),
    .ANCHO_MAX (AMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ancho       (ancho),
    .nuevo       (nuevo),
    .habilitar   (habilitar),
    .pwm         (pwm),
    .tomado      (tomado),
    .fin_periodo (fin_periodo),
    .activo      (activo)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: state of the current cycle.
  bit m_ok  = 1'b0;
  bit m_run = 1'b0;
  int m_cnt = 0;
  int m_act = AMIN;
  bit m_pf  = 1'b0;
  int m_pv  = 0;

  // Observed activity accumulators for scenario checks.
  int obs_pwm = 0;
  int obs_fin = 0;
  int obs_tom = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_w(input int v);
`ifdef SERVO_PWM_CLAMP_EN
    if (v < AMIN) return AMIN;
    if (v > AMAX) return AMAX;
    return v;
`else
    return v;
`endif
  endfunction

  task automatic clear_obs();
    obs_pwm = 0;
    obs_fin = 0;
    obs_tom = 0;
  endtask

  // One clk cycle: drive inputs at the falling edge, check outputs, then
  // advance the model to the following cycle.
  task automatic step(input bit r, input bit h, input bit n, input int a);
    bit last;
    bit e_tom;
    @(negedge clk);
    rst       = r;
    habilitar = h;
    nuevo     = n;
    ancho     = W'(a);
    #1;
    last  = m_run && (m_cnt == P - 1);
    e_tom = !r && ((last && (m_pf || n)) || (!m_run && m_pf));
    if (m_ok) begin
      check("pwm", pwm, (m_run && (m_cnt < m_act)));
      check("fin_periodo", fin_periodo, last);
      check("tomado", tomado, e_tom);
      check("activo", activo, m_act);
    end
    obs_pwm += int'(pwm);
    obs_fin += int'(fin_periodo);
    obs_tom += int'(tomado);

    if (r) begin
      m_ok  = 1'b1;
      m_run = 1'b0;
      m_cnt = 0;
      m_act = AMIN;
      m_pf  = 1'b0;
      m_pv  = 0;
    end else if (last) begin
      if (n) m_act = clamp_w(a);
      else if (m_pf) m_act = m_pv;
      m_pf  = 1'b0;
      m_cnt = 0;
      m_run = h;
    end else begin
      if (!m_run && m_pf) begin
        m_act = m_pv;
        m_pf  = 1'b0;
      end
      if (n) begin
        m_pf = 1'b1;
        m_pv = clamp_w(a);
      end
      if (m_run) m_cnt++;
      else m_run = h;
    end
  endtask

  task automatic run_n(input int n, input bit h);
    repeat (n) step(1'b0, h, 1'b0, 0);
  endtask

  // Advance until the next cycle is a running cycle at count c.
  task automatic idle_until(input int c, input bit h);
    for (int i = 0; i < 300 && !(m_run && m_cnt == c); i++) step(1'b0, h, 1'b0, 0);
    check("reach_cnt", (m_run && m_cnt == c), 1);
  endtask

  initial begin
    bit hab_r;

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    check("rst_activo", activo, AMIN);
    run_n(3, 1'b0);
    check("rst_pwm", pwm, 0);
    check("stopped_fin", obs_fin, 0);

    // Default width: 5 high of every 100, one fin per period
    step(1'b0, 1'b1, 1'b0, 0);
    idle_until(0, 1'b1);
    clear_obs();
    run_n(200, 1'b1);
    check("default_pwm_cycles", obs_pwm, 10);
    check("default_fin_count", obs_fin, 2);

    // Width change mid-period takes effect next period
    idle_until(40, 1'b1);
    clear_obs();
    step(1'b0, 1'b1, 1'b1, 12);
    run_n(59, 1'b1);
    check("mid_pwm_cycles", obs_pwm, 0);
    check("mid_tomado_count", obs_tom, 1);
    clear_obs();
    run_n(100, 1'b1);
    check("w12_pwm_cycles", obs_pwm, 12);
    check("w12_activo", activo, 12);

    // Last write wins, including one landing on the boundary cycle
    idle_until(30, 1'b1);
    clear_obs();
    step(1'b0, 1'b1, 1'b1, 8);
    idle_until(99, 1'b1);
    step(1'b0, 1'b1, 1'b1, 15);
    check("lww_tomado_count", obs_tom, 1);
    clear_obs();
    run_n(100, 1'b1);
    check("lww_pwm_cycles", obs_pwm, 15);
    check("lww_activo", activo, 15);

    // Stop request mid-period: period completes, then output stays idle
    idle_until(3, 1'b1);
    clear_obs();
    run_n(97, 1'b0);
    check("stop_final_fin", obs_fin, 1);
    clear_obs();
    run_n(150, 1'b0);
    check("stopped_pwm_cycles", obs_pwm, 0);
    check("stopped_fin_count", obs_fin, 0);

    // Width captured while stopped is taken on the next clk
    clear_obs();
    step(1'b0, 1'b0, 1'b1, 9);
    run_n(2, 1'b0);
    check("parado_tomado_count", obs_tom, 1);
    check("parado_activo", activo, 9);

    // Restart begins with a full pulse from count 0
    clear_obs();
    step(1'b0, 1'b1, 1'b0, 0);
    run_n(100, 1'b1);
    check("restart_pwm_cycles", obs_pwm, 9);
    check("restart_fin_count", obs_fin, 1);

`ifdef SERVO_PWM_CLAMP_EN
    idle_until(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2);
    idle_until(0, 1'b1);
    check("clamp_low_activo", activo, AMIN);
    idle_until(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 50);
    idle_until(0, 1'b1);
    clear_obs();
    run_n(100, 1'b1);
    check("clamp_high_activo", activo, AMAX);
    check("clamp_high_pwm_cycles", obs_pwm, AMAX);
`else
    idle_until(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 0);
    idle_until(0, 1'b1);
    clear_obs();
    run_n(200, 1'b1);
    check("zero_pwm_cycles", obs_pwm, 0);
    check("zero_fin_count", obs_fin, 2);
    idle_until(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 150);
    idle_until(0, 1'b1);
    clear_obs();
    run_n(200, 1'b1);
    check("full_pwm_cycles", obs_pwm, 200);
    check("full_activo", activo, 150);
`endif

    // Reset during the pulse
    idle_until(50, 1'b1);
    step(1'b0, 1'b1, 1'b1, 9);
    idle_until(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0);
    check("pre_rst_pwm", pwm, 1);
    step(1'b1, 1'b1, 1'b1, 17);
    step(1'b0, 1'b0, 1'b0, 0);
    check("post_rst_pwm", pwm, 0);
    check("post_rst_activo", activo, AMIN);
    clear_obs();
    run_n(120, 1'b0);
    check("post_rst_fin_count", obs_fin, 0);

    // Randomized traffic against the model
    hab_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) hab_r = !hab_r;
      step(($urandom_range(0, 499) == 0), hab_r,
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 150)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
